// File: rtl/hamming_pkg.sv
// Shared constants and elaboration-time helpers for the extended-Hamming (SECDED) codec family.
package hamming_pkg;

    localparam logic MODE_ENC = 1'b1;
    localparam logic MODE_DEC = 1'b0;

    // Smallest r with 2^r >= data_w + r + 1.
    function automatic int unsigned calc_par_w(input int unsigned data_w);
        for (int unsigned r = 1; r < 32'd8; r++) begin
            if ((32'd1 << r) >= (data_w + r + 32'd1)) begin
                return r;
            end
        end
        return 32'd7;
    endfunction

    // True for Hamming positions that carry a parity bit (1, 2, 4, ...).
    function automatic logic is_pow2(input int unsigned pos);
        return (pos != 32'd0) && ((pos & (pos - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/hamming_secded_core.sv
// Combinational SECDED building blocks: encoder, syndrome generator and single-bit corrector.
// The three groups are independent so a pipeline can split them across stages.
module hamming_secded_core
    import hamming_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic [DATA_W-1:0]                  enc_info,
    output logic [DATA_W+calc_par_w(DATA_W):0] enc_code,
    input  logic [DATA_W+calc_par_w(DATA_W):0] dec_code,
    output logic [calc_par_w(DATA_W)-1:0]      dec_syn,
    output logic                               dec_ov,
    input  logic [DATA_W+calc_par_w(DATA_W):0] fix_code,
    input  logic [calc_par_w(DATA_W)-1:0]      fix_syn,
    input  logic                               fix_ov,
    output logic [DATA_W+calc_par_w(DATA_W):0] fix_code_out,
    output logic [DATA_W-1:0]                  fix_info,
    output logic                               fix_corrected,
    output logic                               fix_uncorr
);

    localparam int unsigned PAR_W  = calc_par_w(DATA_W);
    localparam int unsigned CODE_W = DATA_W + PAR_W + 1;

    logic [CODE_W-1:0] scatter;
    logic [CODE_W-1:0] flip_mask;

    // Encoder: scatter data into non-power-of-two positions, then fill parity and overall parity.
    always_comb begin
        int unsigned k;
        logic        par;
        scatter = '0;
        k       = 32'd0;
        for (int unsigned p = 1; p < CODE_W; p++) begin
            if (!is_pow2(p)) begin
                scatter[p] = enc_info[k];
                k          = k + 32'd1;
            end
        end
        enc_code = scatter;
        for (int unsigned i = 0; i < PAR_W; i++) begin
            par = 1'b0;
            for (int unsigned p = 1; p < CODE_W; p++) begin
                if (!is_pow2(p) && (((p >> i) & 32'd1) != 32'd0)) begin
                    par = par ^ scatter[p];
                end
            end
            enc_code[32'd1 << i] = par;
        end
        enc_code[0] = ^enc_code[CODE_W-1:1];
    end

    // Syndrome: each bit covers the positions whose index has that bit set; ov spans the whole word.
    always_comb begin
        dec_syn = '0;
        for (int unsigned i = 0; i < PAR_W; i++) begin
            for (int unsigned p = 1; p < CODE_W; p++) begin
                if (((p >> i) & 32'd1) != 32'd0) begin
                    dec_syn[i] = dec_syn[i] ^ dec_code[p];
                end
            end
        end
        dec_ov = ^dec_code;
    end

    // Corrector: odd overall parity with an in-range syndrome flips that bit (syndrome 0 means bit 0).
    always_comb begin
        flip_mask     = '0;
        fix_corrected = 1'b0;
        fix_uncorr    = 1'b0;
        if (fix_ov) begin
            if (32'(fix_syn) < CODE_W) begin
                flip_mask     = CODE_W'(1) << fix_syn;
                fix_corrected = 1'b1;
            end else begin
                fix_uncorr = 1'b1;
            end
        end else if (fix_syn != '0) begin
            fix_uncorr = 1'b1;
        end
        fix_code_out = fix_code ^ flip_mask;
    end

    // Info extraction from the (possibly corrected) codeword.
    always_comb begin
        int unsigned k;
        fix_info = '0;
        k        = 32'd0;
        for (int unsigned p = 1; p < CODE_W; p++) begin
            if (!is_pow2(p)) begin
                fix_info[k] = fix_code_out[p];
                k           = k + 32'd1;
            end
        end
    end

endmodule

// File: rtl/hamming_secded_pipe.sv
// Two-stage valid/ready SECDED encode/decode pipeline with saturating error counters.
// Stage 1 holds the word plus its syndrome; stage 2 holds the encoded or corrected result.
// Optional build macro HAMMING_ERR_INJECT_EN adds inj_mask, XORed onto encoded words.
module hamming_secded_pipe
    import hamming_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               in_mode,
    input  logic [DATA_W+calc_par_w(DATA_W):0] in_data,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic [DATA_W+calc_par_w(DATA_W):0] inj_mask,
`endif
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_W+calc_par_w(DATA_W):0] out_data,
    output logic [DATA_W-1:0]                  out_info,
    output logic [calc_par_w(DATA_W):0]        out_syndrome,
    output logic                               out_corrected,
    output logic                               out_uncorr,
    input  logic                               clr_cnt,
    output logic [CNT_W-1:0]                   cnt_corr,
    output logic [CNT_W-1:0]                   cnt_uncorr
);

    localparam int unsigned PAR_W  = calc_par_w(DATA_W);
    localparam int unsigned CODE_W = DATA_W + PAR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              s1_valid;
    logic              s1_mode;
    logic [CODE_W-1:0] s1_code;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_ov;
    logic [CODE_W-1:0] s1_inj;

    logic              s2_adv_c;
    logic [PAR_W-1:0]  in_syn_c;
    logic              in_ov_c;
    logic [CODE_W-1:0] enc_code_c;
    logic [CODE_W-1:0] fix_code_c;
    logic [DATA_W-1:0] fix_info_c;
    logic              fix_corr_c;
    logic              fix_uncorr_c;
    logic              inc_corr_c;
    logic              inc_uncorr_c;

    logic [CODE_W-1:0] unused_front_enc;
    logic [CODE_W-1:0] unused_front_fix_code;
    logic [DATA_W-1:0] unused_front_fix_info;
    logic              unused_front_corr;
    logic              unused_front_uncorr;
    logic [PAR_W-1:0]  unused_back_syn;
    logic              unused_back_ov;

    // Handshake: stage 2 drains when empty or consumed; stage 1 accepts when empty or moving on.
    assign s2_adv_c = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv_c;

    // Front instance: syndrome and overall parity of the incoming word.
    hamming_secded_core #(
        .DATA_W (DATA_W)
    ) u_front (
        .enc_info      ('0),
        .enc_code      (unused_front_enc),
        .dec_code      (in_data),
        .dec_syn       (in_syn_c),
        .dec_ov        (in_ov_c),
        .fix_code      ('0),
        .fix_syn       ('0),
        .fix_ov        (1'b0),
        .fix_code_out  (unused_front_fix_code),
        .fix_info      (unused_front_fix_info),
        .fix_corrected (unused_front_corr),
        .fix_uncorr    (unused_front_uncorr)
    );

    // Back instance: encode and correct the stage-1 word using its registered syndrome.
    hamming_secded_core #(
        .DATA_W (DATA_W)
    ) u_back (
        .enc_info      (s1_code[DATA_W-1:0]),
        .enc_code      (enc_code_c),
        .dec_code      (s1_code),
        .dec_syn       (unused_back_syn),
        .dec_ov        (unused_back_ov),
        .fix_code      (s1_code),
        .fix_syn       (s1_syn),
        .fix_ov        (s1_ov),
        .fix_code_out  (fix_code_c),
        .fix_info      (fix_info_c),
        .fix_corrected (fix_corr_c),
        .fix_uncorr    (fix_uncorr_c)
    );

    // Stage 1 register: mode, raw word and syndrome, captured at the input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_DEC;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_ov    <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= in_mode;
                s1_code <= in_data;
                s1_syn  <= in_syn_c;
                s1_ov   <= in_ov_c;
            end
        end
    end

`ifdef HAMMING_ERR_INJECT_EN
    // Injection mask travels with its word through stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_inj <= '0;
        end else if (in_ready && in_valid) begin
            s1_inj <= inj_mask;
        end
    end
`else
    assign s1_inj = '0;
`endif

    // Stage 2 register: result fields only load on an advance, so they hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_info      <= '0;
            out_syndrome  <= '0;
            out_corrected <= 1'b0;
            out_uncorr    <= 1'b0;
        end else if (s2_adv_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                if (s1_mode == MODE_ENC) begin
                    out_data      <= enc_code_c ^ s1_inj;
                    out_info      <= s1_code[DATA_W-1:0];
                    out_syndrome  <= '0;
                    out_corrected <= 1'b0;
                    out_uncorr    <= 1'b0;
                end else begin
                    out_data      <= fix_code_c;
                    out_info      <= fix_info_c;
                    out_syndrome  <= {s1_ov, s1_syn};
                    out_corrected <= fix_corr_c;
                    out_uncorr    <= fix_uncorr_c;
                end
            end
        end
    end

    assign inc_corr_c   = s2_adv_c && s1_valid && (s1_mode == MODE_DEC) && fix_corr_c;
    assign inc_uncorr_c = s2_adv_c && s1_valid && (s1_mode == MODE_DEC) && fix_uncorr_c;

    // Saturating error counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (clr_cnt) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else begin
            if (inc_corr_c && (cnt_corr != CNT_MAX)) begin
                cnt_corr <= cnt_corr + CNT_W'(1);
            end
            if (inc_uncorr_c && (cnt_uncorr != CNT_MAX)) begin
                cnt_uncorr <= cnt_uncorr + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Directed bench for hamming_secded_pipe (DATA_W=4, CNT_W=2) with hand-computed codewords.
module tb_hamming_secded_pipe;
    import hamming_pkg::*;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned N_STR  = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [3:0]  out_info;
    logic [3:0]  out_syndrome;
    logic        out_corrected;
    logic        out_uncorr;
    logic        clr_cnt;
    logic [1:0]  cnt_corr;
    logic [1:0]  cnt_uncorr;
`ifdef HAMMING_ERR_INJECT_EN
    logic [7:0]  inj_mask;
`endif

    logic [17:0] obs;
    int          checks = 0;
    int          errors = 0;

    // obs layout: {data[7:0], info[3:0], syndrome[3:0], corrected, uncorr}
    assign obs = {out_data, out_info, out_syndrome, out_corrected, out_uncorr};

    always #5 clk = ~clk;

    hamming_secded_pipe #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mode       (in_mode),
        .in_data       (in_data),
`ifdef HAMMING_ERR_INJECT_EN
        .inj_mask      (inj_mask),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_info      (out_info),
        .out_syndrome  (out_syndrome),
        .out_corrected (out_corrected),
        .out_uncorr    (out_uncorr),
        .clr_cnt       (clr_cnt),
        .cnt_corr      (cnt_corr),
        .cnt_uncorr    (cnt_uncorr)
    );

    // Present one word at the current falling edge; return falling edges until out_valid.
    task automatic run_one(input logic mode, input logic [7:0] data, output int lat);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_mode = MODE_DEC; in_data = 8'h00;
        out_ready = 1'b1; clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if ({cnt_corr, cnt_uncorr} !== 4'h0) begin errors++; $display("FAIL reset_counters: got %h/%h expected 0/0", cnt_corr, cnt_uncorr); end
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL reset_fields: got %h expected 0", obs); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_encode();
        int lat;
        run_one(MODE_ENC, 8'h0B, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL enc_latency: got %0d expected 2", lat); end
        checks++;
        if (obs !== {8'hAA, 4'hB, 4'h0, 1'b0, 1'b0}) begin errors++; $display("FAIL enc_B: got %h expected %h", obs, {8'hAA, 4'hB, 4'h0, 1'b0, 1'b0}); end
    endtask

    task automatic test_decode_clean();
        int lat;
        run_one(MODE_DEC, 8'hAA, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL dec_clean_latency: got %0d expected 2", lat); end
        checks++;
        if (obs !== {8'hAA, 4'hB, 4'h0, 1'b0, 1'b0}) begin errors++; $display("FAIL dec_clean: got %h expected %h", obs, {8'hAA, 4'hB, 4'h0, 1'b0, 1'b0}); end
        checks++;
        if ({cnt_corr, cnt_uncorr} !== 4'h0) begin errors++; $display("FAIL dec_clean_counters: got %h/%h expected 0/0", cnt_corr, cnt_uncorr); end
    endtask

    task automatic test_single_error();
        int lat;
        run_one(MODE_DEC, 8'h8A, lat);
        checks++;
        if (obs !== {8'hAA, 4'hB, 4'hD, 1'b1, 1'b0}) begin errors++; $display("FAIL dec_bit5: got %h expected %h", obs, {8'hAA, 4'hB, 4'hD, 1'b1, 1'b0}); end
        checks++;
        if (cnt_corr !== 2'd1) begin errors++; $display("FAIL dec_bit5_cnt: got %0d expected 1", cnt_corr); end
        run_one(MODE_DEC, 8'hAB, lat);
        checks++;
        if (obs !== {8'hAA, 4'hB, 4'h8, 1'b1, 1'b0}) begin errors++; $display("FAIL dec_bit0: got %h expected %h", obs, {8'hAA, 4'hB, 4'h8, 1'b1, 1'b0}); end
        checks++;
        if (cnt_corr !== 2'd2) begin errors++; $display("FAIL dec_bit0_cnt: got %0d expected 2", cnt_corr); end
    endtask

    task automatic test_double_error();
        int lat;
        run_one(MODE_DEC, 8'h82, lat);
        checks++;
        if (obs !== {8'h82, 4'h8, 4'h6, 1'b0, 1'b1}) begin errors++; $display("FAIL dec_double: got %h expected %h", obs, {8'h82, 4'h8, 4'h6, 1'b0, 1'b1}); end
        checks++;
        if ({cnt_corr, cnt_uncorr} !== {2'd2, 2'd1}) begin errors++; $display("FAIL dec_double_cnt: got %0d/%0d expected 2/1", cnt_corr, cnt_uncorr); end
    endtask

    task automatic test_counters();
        int lat;
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        checks++;
        if ({cnt_corr, cnt_uncorr} !== 4'h0) begin errors++; $display("FAIL cnt_clear: got %0d/%0d expected 0/0", cnt_corr, cnt_uncorr); end
        for (int i = 0; i < 5; i++) begin
            run_one(MODE_DEC, 8'h8A, lat);
            checks++;
            if (cnt_corr !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin
                errors++;
                $display("FAIL cnt_saturate[%0d]: got %0d expected %0d", i, cnt_corr, (i < 3) ? (i + 1) : 3);
            end
        end
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        run_one(MODE_DEC, 8'h8A, lat);
        checks++;
        if (cnt_corr !== 2'd1) begin errors++; $display("FAIL cnt_after_clear: got %0d expected 1", cnt_corr); end
        // Corrected word reaches stage 2 on the same edge that clr_cnt is high.
        in_valid = 1'b1; in_mode = MODE_DEC; in_data = 8'h8A;
        @(negedge clk);
        in_valid = 1'b0; clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        checks++;
        if ({out_valid, out_corrected, cnt_corr} !== {1'b1, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL cnt_clr_wins: got valid=%b corr=%b cnt=%0d expected 1 1 0", out_valid, out_corrected, cnt_corr);
        end
    endtask

    task automatic test_back_to_back();
        logic        vmode [N_STR];
        logic [7:0]  vin   [N_STR];
        logic [17:0] vexp  [N_STR];
        logic [18:0] snap;
        logic        held;
        int          in_idx;
        int          out_idx;
        int          cyc;
        vmode = '{MODE_ENC, MODE_DEC, MODE_ENC, MODE_DEC, MODE_ENC, MODE_DEC,
                  MODE_DEC, MODE_ENC, MODE_DEC, MODE_DEC, MODE_ENC, MODE_DEC};
        vin   = '{8'h05, 8'h5A, 8'hFC, 8'hD3, 8'h07, 8'h68,
                  8'hE2, 8'h03, 8'hBF, 8'h00, 8'h0A, 8'hA7};
        vexp  = '{{8'h5A, 4'h5, 4'h0, 1'b0, 1'b0}, {8'h5A, 4'h5, 4'h0, 1'b0, 1'b0},
                  {8'hC3, 4'hC, 4'h0, 1'b0, 1'b0}, {8'hC3, 4'hC, 4'hC, 1'b1, 1'b0},
                  {8'h69, 4'h7, 4'h0, 1'b0, 1'b0}, {8'h69, 4'h7, 4'h8, 1'b1, 1'b0},
                  {8'hE2, 4'hE, 4'h5, 1'b0, 1'b1}, {8'h3C, 4'h3, 4'h0, 1'b0, 1'b0},
                  {8'hFF, 4'hF, 4'hE, 1'b1, 1'b0}, {8'h00, 4'h0, 4'h0, 1'b0, 1'b0},
                  {8'hA5, 4'hA, 4'h0, 1'b0, 1'b0}, {8'hA5, 4'hA, 4'h9, 1'b1, 1'b0}};
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        held = 1'b0; snap = '0; in_idx = 0; out_idx = 0; cyc = 0;
        while (out_idx < N_STR && cyc < 400) begin
            if (held) begin
                checks++;
                if ({out_valid, obs} !== snap) begin errors++; $display("FAIL stall_hold[%0d]: got %h expected %h", out_idx, {out_valid, obs}, snap); end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_idx < N_STR) begin
                in_valid = 1'b1; in_mode = vmode[in_idx]; in_data = vin[in_idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (obs !== vexp[out_idx]) begin errors++; $display("FAIL stream[%0d]: got %h expected %h", out_idx, obs, vexp[out_idx]); end
                out_idx++;
            end
            held = out_valid && !out_ready;
            snap = {out_valid, obs};
            if (in_valid && in_ready) in_idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (out_idx != N_STR) begin errors++; $display("FAIL stream_count: got %0d expected %0d", out_idx, N_STR); end
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_no_dup: got out_valid %b expected 0", out_valid); end
        checks++;
        if ({cnt_corr, cnt_uncorr} !== {2'd3, 2'd1}) begin errors++; $display("FAIL stream_cnt: got %0d/%0d expected 3/1", cnt_corr, cnt_uncorr); end
    endtask

    task automatic test_reset_in_flight();
        int lat;
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = MODE_DEC; in_data = 8'h8A;
        @(negedge clk);
        in_data = 8'h82;
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'h00;
        checks++;
        if ({out_valid, out_corrected} !== 2'b11) begin errors++; $display("FAIL flight_pre: got valid=%b corr=%b expected 1 1", out_valid, out_corrected); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, cnt_corr, cnt_uncorr} !== 5'b0) begin
            errors++;
            $display("FAIL flight_reset: got valid=%b cnt=%0d/%0d expected 0 0/0", out_valid, cnt_corr, cnt_uncorr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flight_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_discard: got out_valid %b expected 0", out_valid); end
        run_one(MODE_ENC, 8'h08, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL flight_latency: got %0d expected 2", lat); end
        checks++;
        if (obs !== {8'h96, 4'h8, 4'h0, 1'b0, 1'b0}) begin errors++; $display("FAIL flight_enc8: got %h expected %h", obs, {8'h96, 4'h8, 4'h0, 1'b0, 1'b0}); end
    endtask

    initial begin
`ifdef HAMMING_ERR_INJECT_EN
        inj_mask = 8'h00;
`endif
        test_reset();
        test_encode();
        test_decode_clean();
        test_single_error();
        test_double_error();
        test_counters();
        test_back_to_back();
        test_reset_in_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
